// File: rtl/dsi_pkg.sv
// Shared types and constants for the DSI transmit scheduler.
// State encoding, default gap/timeout lengths and lane-interface widths.
package dsi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LP_SETUP,
        ST_LP_XFER,
        ST_LP_HOLD,
        ST_HS_XFER,
        ST_HS_DRAIN,
        ST_GAP
    } dsi_state_t;

    localparam int DSI_GAP_CYCLES_DEF     = 8;
    localparam int DSI_TIMEOUT_CYCLES_DEF = 4096;
    localparam int DSI_DATA_W             = 32;
    localparam int DSI_STRB_W             = 4;

endpackage

// File: rtl/dsi_rr_arbiter2.sv
// Two-input HS/LP arbiter: optional LP priority, otherwise round-robin
// on a registered last-served pointer.
module dsi_rr_arbiter2 (
    input  logic clk_sys,
    input  logic rst,
    input  logic req_hs,
    input  logic req_lp,
    input  logic lp_priority,
    input  logic take,
    output logic win_hs,
    output logic win_lp
);

    // 1 when LP was the last requester served; reset treats HS as last.
    logic last_lp;

    always_comb begin
        win_hs = 1'b0;
        win_lp = 1'b0;
        if (req_hs && req_lp) begin
            if (lp_priority || !last_lp) begin
                win_lp = 1'b1;
            end else begin
                win_hs = 1'b1;
            end
        end else if (req_lp) begin
            win_lp = 1'b1;
        end else if (req_hs) begin
            win_hs = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            last_lp <= 1'b0;
        end else if (take && (win_hs || win_lp)) begin
            last_lp <= win_lp;
        end
    end

endmodule

// File: rtl/dsi_tx_scheduler.sv
// Schedules HS video and LP command packets onto the DSI lanes controller,
// with inter-packet gap, watchdog abort and clock-loss abort.
module dsi_tx_scheduler
    import dsi_pkg::*;
#(
    parameter int GAP_CYCLES     = DSI_GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = DSI_TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  hs_req,
    input  logic [DSI_DATA_W-1:0] hs_data,
    input  logic [DSI_STRB_W-1:0] hs_strb,
    input  logic                  hs_last,
    output logic                  hs_data_rqst,
    input  logic                  lp_req,
    input  logic [DSI_DATA_W-1:0] lp_data,
    input  logic [DSI_STRB_W-1:0] lp_strb,
    input  logic                  lp_last,
    output logic                  lp_data_rqst,
    output logic [DSI_DATA_W-1:0] iface_write_data,
    output logic [DSI_STRB_W-1:0] iface_write_strb,
    output logic                  iface_write_rqst,
    output logic                  iface_last_word,
    output logic                  iface_lpm_en,
    input  logic                  iface_data_rqst,
    input  logic                  lines_active,
    input  logic                  clock_ready,
    input  logic                  sched_en,
    input  logic                  lp_priority,
    output logic                  busy,
    output logic                  abort_pulse,
    output logic                  grant_hs,
    output logic                  grant_lp
);

    localparam logic [7:0]  GAP_LOAD = 8'(GAP_CYCLES - 1);
    localparam logic [15:0] WDOG_MAX = 16'(TIMEOUT_CYCLES - 1);

    dsi_state_t  state;
    dsi_state_t  state_nxt;
    logic [7:0]  gap_cnt;
    logic [15:0] wdog_cnt;
    logic        grant_ok;
    logic        win_hs;
    logic        win_lp;
    logic        watched;
    logic        abort;

    assign grant_ok = sched_en && clock_ready && !lines_active;
    assign watched  = (state == ST_LP_XFER) || (state == ST_HS_XFER) || (state == ST_HS_DRAIN);
    // Clock loss is handled exactly like a watchdog expiry.
    assign abort       = watched && (!clock_ready || (!iface_data_rqst && (wdog_cnt == WDOG_MAX)));
    assign abort_pulse = abort;
    assign busy        = (state != ST_IDLE);

    dsi_rr_arbiter2 u_arb (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .req_hs      (hs_req),
        .req_lp      (lp_req),
        .lp_priority (lp_priority),
        .take        ((state == ST_IDLE) && grant_ok),
        .win_hs      (win_hs),
        .win_lp      (win_lp)
    );

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Gap counter loads on GAP entry; nothing but its own count ends the gap.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            gap_cnt <= 8'd0;
        end else if ((state_nxt == ST_GAP) && (state != ST_GAP)) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == ST_GAP) && (gap_cnt != 8'd0)) begin
            gap_cnt <= gap_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wdog_cnt <= 16'd0;
        end else if (!watched || (state_nxt != state) || iface_data_rqst) begin
            wdog_cnt <= 16'd0;
        end else begin
            wdog_cnt <= wdog_cnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt        = state;
        iface_write_data = '0;
        iface_write_strb = '0;
        iface_write_rqst = 1'b0;
        iface_last_word  = 1'b0;
        iface_lpm_en     = 1'b0;
        hs_data_rqst     = 1'b0;
        lp_data_rqst     = 1'b0;
        grant_hs         = 1'b0;
        grant_lp         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_ok && win_lp) begin
                    state_nxt = ST_LP_SETUP;
                end else if (grant_ok && win_hs) begin
                    state_nxt = ST_HS_XFER;
                end
            end
            ST_LP_SETUP: begin
                grant_lp     = 1'b1;
                iface_lpm_en = 1'b1;
                state_nxt    = ST_LP_XFER;
            end
            ST_LP_XFER: begin
                grant_lp         = 1'b1;
                iface_lpm_en     = 1'b1;
                iface_write_rqst = 1'b1;
                iface_write_data = lp_data;
                iface_write_strb = lp_strb;
                lp_data_rqst     = iface_data_rqst;
                if (abort || (lp_last && iface_data_rqst)) begin
                    iface_last_word = 1'b1;
                    state_nxt       = ST_LP_HOLD;
                end
            end
            ST_LP_HOLD: begin
                grant_lp     = 1'b1;
                iface_lpm_en = 1'b1;
                state_nxt    = ST_GAP;
            end
            ST_HS_XFER: begin
                grant_hs         = 1'b1;
                iface_write_rqst = 1'b1;
                iface_write_data = hs_data;
                iface_write_strb = hs_strb;
                hs_data_rqst     = iface_data_rqst;
                if (abort) begin
                    iface_last_word = 1'b1;
                    state_nxt       = ST_GAP;
                end else if (hs_last && iface_data_rqst) begin
                    iface_last_word = 1'b1;
                    state_nxt       = ST_HS_DRAIN;
                end
            end
            ST_HS_DRAIN: begin
                grant_hs = 1'b1;
                if (abort) begin
                    iface_last_word = 1'b1;
                    state_nxt       = ST_GAP;
                end else if (!lines_active) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
